cgra_conf_dist: RTL and testbench
=================================

CGRA_CONF_DIST -- requirements
Module: cgra_conf_dist

Interface
REQ-001 Parameter NUM_PE, default 4, number of PEs on the configuration chain (legal 1..64).
REQ-002 Parameter CONF_WIDTH, default 64, configuration word width in bits.
REQ-003 Parameter CNT_WIDTH, default 16, width of the word counter and conf_num_words.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 en  input  1  global run enable from the host.
REQ-008 start  input  1  one-cycle request to begin a configuration load.
REQ-009 conf_num_words  input  CNT_WIDTH  number of words to load; sampled on the start cycle.
REQ-010 conf_in_valid  input  1  configuration word valid.
REQ-011 conf_in_data  input  CONF_WIDTH  configuration word.
REQ-012 conf_in_ready  output  1  configuration word accepted when valid and ready are both high.
REQ-013 conf_taps  output  (NUM_PE+1)*CONF_WIDTH  flattened taps; tap k is slice [k*CONF_WIDTH +: CONF_WIDTH]; taps 0..NUM_PE-1 feed the PEs and tap NUM_PE feeds the networks.
REQ-014 cgra_en  output  1  gated enable to the PEs and networks.
REQ-015 busy  output  1  high in LOAD and DRAIN.
REQ-016 done  output  1  one-cycle pulse when a load completes.

Function
REQ-017 FSM states: IDLE, LOAD, DRAIN, DONE.
REQ-018 IDLE: start=1 with conf_num_words>0 -> LOAD, latching conf_num_words into word_cnt_target and clearing word_cnt; start=1 with conf_num_words=0 -> DRAIN.
REQ-019 LOAD: conf_in_ready=1; each handshake increments word_cnt; the handshake that makes word_cnt equal to word_cnt_target moves the FSM to DRAIN on the next edge.
REQ-020 conf_in_ready shall be 0 in every state except LOAD, so the word count never exceeds the latched target.
REQ-021 Stage 0 shall register conf_in_data on a handshake cycle and all-zeros (NOP bubble) otherwise; stage k (k>=1) shall register stage k-1 every cycle; tap k = stage k output.
REQ-022 Latency: a word accepted in cycle t shall appear on tap k in cycle t+1+k.
REQ-023 DRAIN shall last exactly NUM_PE+1 cycles, counted by drain_cnt, then move to DONE; the last word is therefore present on tap NUM_PE on the final DRAIN cycle.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 cgra_en = en AND (state is IDLE or DONE); cgra_en shall be 0 in LOAD and DRAIN regardless of en.
REQ-026 A start asserted in LOAD, DRAIN or DONE shall be ignored and shall not be queued.
REQ-027 A conf_in_valid stall (valid=0) in LOAD shall insert zero bubbles with no word loss; the FSM shall remain in LOAD indefinitely until the target count is reached.
REQ-028 word_cnt shall not wrap; the maximum target is 2^CNT_WIDTH-1.

Reset
REQ-029 While rst=0: FSM in IDLE, all stages zero, word_cnt, word_cnt_target and drain_cnt zero, conf_in_ready=0, busy=0, done=0, cgra_en=0.
REQ-030 Reset asserted mid-LOAD or mid-DRAIN shall abort immediately, with no done pulse; after release the block is in IDLE with all taps zero.

Structure
REQ-031 Package cgra_pkg shall hold the FSM state encoding and the default CONF_WIDTH constant.
REQ-032 One sub-module, cgra_conf_stage (a CONF_WIDTH register with async active-low reset), shall be instantiated NUM_PE+1 times using a generate loop.

Verification
REQ-033 NUM_PE=4, start with num_words=3, words A,B,C on consecutive cycles from t0 -> A on tap0 at t0+1 and on tap4 at t0+5; done pulses once, 5 cycles after DRAIN entry.
REQ-034 num_words=2 with a 3-cycle valid gap between the words -> zero bubbles appear on tap0 for 3 cycles; both words propagate; conf_in_ready drops after the second word.
REQ-035 start with num_words=0 -> no handshake occurs; busy is high for 5 cycles; done pulses; all taps stay zero.
REQ-036 en=1 throughout a load -> cgra_en is 0 from the LOAD entry through the last DRAIN cycle and 1 in DONE and IDLE.
REQ-037 Repeated start during LOAD -> target unchanged and exactly one done pulse.
REQ-038 rst low in the second DRAIN cycle -> all taps 0 and the FSM in IDLE immediately; no done pulse after release.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA configuration distributor: FSM state
// encoding and the default configuration word width.
package cgra_pkg;

  localparam int CONF_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : cgra_pkg

// File: rtl/cgra_conf_dist_if.sv
// Configuration word stream into the distributor.
// Handshake: a word transfers on a rising clock edge where conf_in_valid and
// conf_in_ready are both high. The master holds conf_in_data stable with
// conf_in_valid; the slave may drive conf_in_ready without looking at valid.
interface cgra_conf_dist_if #(
  parameter int CONF_WIDTH = cgra_pkg::CONF_WIDTH_DEF
);

  logic                  conf_in_valid;
  logic [CONF_WIDTH-1:0] conf_in_data;
  logic                  conf_in_ready;

  modport master (
    output conf_in_valid,
    output conf_in_data,
    input  conf_in_ready
  );

  modport slave (
    input  conf_in_valid,
    input  conf_in_data,
    output conf_in_ready
  );

endinterface : cgra_conf_dist_if

// File: rtl/cgra_conf_stage.sv
// One stage of the configuration shift chain: a plain register of
// configuration-word width with asynchronous active-low clear.
module cgra_conf_stage #(
  parameter int CONF_WIDTH = cgra_pkg::CONF_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CONF_WIDTH-1:0] i_d,
  output logic [CONF_WIDTH-1:0] o_q
);

  logic [CONF_WIDTH-1:0] r_q;

  // Capture the upstream word every cycle; reset clears to a NOP word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else          r_q <= i_d;
  end

  assign o_q = r_q;

endmodule : cgra_conf_stage

// File: rtl/cgra_conf_dist.sv
// CGRA configuration distributor. Accepts a counted burst of configuration
// words, pushes them down a NUM_PE+1 stage chain (one tap per PE plus one
// for the networks), lets the chain drain, then pulses done. The array
// enable is withheld while configuration is moving.
module cgra_conf_dist
  import cgra_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int CONF_WIDTH = CONF_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             conf_num_words,
  cgra_conf_dist_if.slave                  conf_if,
  output logic [(NUM_PE+1)*CONF_WIDTH-1:0] conf_taps,
  output logic                             cgra_en,
  output logic                             busy,
  output logic                             done,
  output state_t                           dbg_state
);

  localparam int NUM_STAGES = NUM_PE + 1;
  // drain_cnt runs 0..NUM_PE, i.e. NUM_PE+1 DRAIN cycles.
  localparam int DW = (NUM_PE < 1) ? 1 : $clog2(NUM_PE + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NUM_PE);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_word_cnt_target;
  logic [CNT_WIDTH-1:0]  w_word_cnt_inc;
  logic [DW-1:0]         r_drain_cnt;
  logic                  w_ready;
  logic                  w_hs;
  logic                  w_last_word;
  logic                  w_drain_end;
  logic                  w_start_load;
  logic [CONF_WIDTH-1:0] w_stage_d [NUM_STAGES];
  logic [CONF_WIDTH-1:0] w_stage_q [NUM_STAGES];

  // Ready only in LOAD, so the accepted count can never pass the target.
  assign w_ready               = (r_state == ST_LOAD);
  assign conf_if.conf_in_ready = w_ready;
  assign w_hs                  = conf_if.conf_in_valid & w_ready;
  assign w_word_cnt_inc        = r_word_cnt + CNT_WIDTH'(1);
  assign w_last_word           = w_hs & (w_word_cnt_inc == r_word_cnt_target);
  assign w_drain_end           = (r_drain_cnt == DRAIN_LAST);
  assign w_start_load          = (r_state == ST_IDLE) & start & (conf_num_words != '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = (conf_num_words != '0) ? ST_LOAD : ST_DRAIN;
      end
      ST_LOAD: begin
        if (w_last_word) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_end) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Word counter and target: latched on a load start, counted per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt        <= '0;
      r_word_cnt_target <= '0;
    end else if (w_start_load) begin
      r_word_cnt        <= '0;
      r_word_cnt_target <= conf_num_words;
    end else if (w_hs) begin
      r_word_cnt        <= w_word_cnt_inc;
    end
  end

  // Drain counter: advances through DRAIN, held at zero elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_drain_cnt <= '0;
    else if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + DW'(1);
    else                          r_drain_cnt <= '0;
  end

  // Stage 0 takes the accepted word, or a zero NOP bubble when nothing moved.
  assign w_stage_d[0] = w_hs ? conf_if.conf_in_data : '0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g > 0) begin : g_link
      assign w_stage_d[g] = w_stage_q[g-1];
    end
    cgra_conf_stage #(
      .CONF_WIDTH (CONF_WIDTH)
    ) u_stage (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_d     (w_stage_d[g]),
      .o_q     (w_stage_q[g])
    );
    assign conf_taps[g*CONF_WIDTH +: CONF_WIDTH] = w_stage_q[g];
  end

  // Reset is folded into cgra_en so the array stays disabled while held.
  assign busy      = (r_state == ST_LOAD) | (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign cgra_en   = en & rst & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign dbg_state = r_state;

endmodule : cgra_conf_dist

// File: tb/tb_cgra_conf_dist.sv
// Bench for cgra_conf_dist: directed scenarios with literal expectations,
// then randomized loads, all checked every cycle against a load-level model.
module tb_cgra_conf_dist;
  import cgra_pkg::*;

  localparam int NUM_PE = 4;
  localparam int CW     = 64;
  localparam int CNTW   = 16;
  localparam int NT     = NUM_PE + 1;
  localparam int TW     = NT * CW;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic            en    = 1'b0;
  logic            start = 1'b0;
  logic [CNTW-1:0] num   = '0;
  logic [TW-1:0]   taps;
  logic            cgra_en;
  logic            busy;
  logic            done;
  state_t          dbg_state;

  cgra_conf_dist_if #(.CONF_WIDTH(CW)) cif ();

  cgra_conf_dist #(
    .NUM_PE     (NUM_PE),
    .CONF_WIDTH (CW),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .start          (start),
    .conf_num_words (num),
    .conf_if        (cif),
    .conf_taps      (taps),
    .cgra_en        (cgra_en),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the load at the level of "words still owed" and "drain cycles
  // left"; tap k shows whatever entered the chain k+1 edges ago.
  int             m_phase = P_IDLE;
  int             m_left  = 0;
  int             m_drain_left = 0;
  logic [CW-1:0]  m_log[$];

  always @(posedge clk or negedge rst) begin : model_p
    logic          acc;
    logic [CW-1:0] w;
    if (!rst) begin
      m_phase      = P_IDLE;
      m_left       = 0;
      m_drain_left = 0;
      m_log.delete();
    end else begin
      acc = (m_phase == P_LOAD) && cif.conf_in_valid;
      w   = acc ? cif.conf_in_data : '0;
      m_log.push_front(w);
      if (m_log.size() > NT) void'(m_log.pop_back());
      case (m_phase)
        P_IDLE: if (start) begin
          if (num != 0) begin m_phase = P_LOAD; m_left = int'(num); end
          else begin m_phase = P_DRAIN; m_drain_left = NUM_PE + 1; end
        end
        P_LOAD: if (acc) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_DRAIN; m_drain_left = NUM_PE + 1; end
        end
        P_DRAIN: begin
          m_drain_left--;
          if (m_drain_left == 0) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin : compare_p
    logic [TW-1:0] exp_taps;
    exp_taps = '0;
    for (int k = 0; k < NT; k++)
      if (k < m_log.size()) exp_taps[k*CW +: CW] = m_log[k];
    chk("taps",    taps,                        exp_taps);
    chk("ready",   TW'(cif.conf_in_ready),      TW'(m_phase == P_LOAD));
    chk("busy",    TW'(busy),                   TW'(m_phase == P_LOAD || m_phase == P_DRAIN));
    chk("done",    TW'(done),                   TW'(m_phase == P_DONE));
    chk("cgra_en", TW'(cgra_en),
        TW'(rst && en && (m_phase == P_IDLE || m_phase == P_DONE)));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_phase == P_IDLE) break;
    end
    chk(name, TW'(m_phase == P_IDLE), TW'(1));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [CW-1:0] WA = 64'hA0A0_0000_1111_000A;
  localparam logic [CW-1:0] WB = 64'hB0B0_0000_2222_000B;
  localparam logic [CW-1:0] WC = 64'hC0C0_0000_3333_000C;
  localparam logic [CW-1:0] WD = 64'hD0D0_4444_0000_000D;
  localparam logic [CW-1:0] WE = 64'hE0E0_5555_0000_000E;

  initial begin : stim_p
    int cnt_busy, cnt_done, cnt_ready;
    cif.conf_in_valid = 1'b0;
    cif.conf_in_data  = '0;

    // Reset
    repeat (3) step();
    en = 1'b1;
    @(negedge clk);
    chk("rst_taps",    taps,          '0);
    chk("rst_cgra_en", TW'(cgra_en),  TW'(0));
    chk("rst_ready",   TW'(cif.conf_in_ready), TW'(0));
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("idle_cgra_en", TW'(cgra_en), TW'(1));

    // Three back-to-back words
    step();
    start = 1'b1; num = 16'd3;
    step();
    start = 1'b0;
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WA;
    @(negedge clk);
    chk("load_ready",   TW'(cif.conf_in_ready), TW'(1));
    chk("load_cgra_en", TW'(cgra_en), TW'(0));
    step();
    cif.conf_in_data = WB;
    @(negedge clk);
    chk("a_tap0", TW'(taps[0*CW +: CW]), TW'(WA));
    step();
    cif.conf_in_data = WC;
    step();
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    @(negedge clk);
    chk("drain_busy",  TW'(busy), TW'(1));
    chk("drain_ready", TW'(cif.conf_in_ready), TW'(0));
    step();
    step();
    @(negedge clk);
    chk("a_tap4", TW'(taps[4*CW +: CW]), TW'(WA));
    step();
    step();
    @(negedge clk);
    chk("c_tap4_last_drain", TW'(taps[4*CW +: CW]), TW'(WC));
    chk("drain_last_done",   TW'(done), TW'(0));
    step();
    @(negedge clk);
    chk("done_pulse",   TW'(done),    TW'(1));
    chk("done_cgra_en", TW'(cgra_en), TW'(1));
    step();
    @(negedge clk);
    chk("done_cleared", TW'(done), TW'(0));

    // Two words with a three-cycle valid gap
    step();
    start = 1'b1; num = 16'd2;
    step();
    start = 1'b0;
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WD;
    step();
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    @(negedge clk);
    chk("d_tap0", TW'(taps[0*CW +: CW]), TW'(WD));
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("gap_bubble", TW'(taps[0*CW +: CW]), TW'(0));
      chk("gap_ready",  TW'(cif.conf_in_ready), TW'(1));
    end
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WE;
    step();
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    @(negedge clk);
    chk("e_tap0",      TW'(taps[0*CW +: CW]), TW'(WE));
    chk("e_ready_off", TW'(cif.conf_in_ready), TW'(0));
    wait_idle("gap_load_finished");

    // Zero-word load
    start = 1'b1; num = 16'd0;
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WA;
    step();
    start = 1'b0;
    cnt_busy = 0; cnt_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cnt_busy++;
      if (done) cnt_done++;
      step();
    end
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    chk("zero_busy_cycles", TW'(cnt_busy), TW'(5));
    chk("zero_done_count",  TW'(cnt_done), TW'(1));

    // Repeated start during LOAD and DRAIN is ignored
    start = 1'b1; num = 16'd2;
    step();
    start = 1'b0;
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WB;
    step();
    start = 1'b1; num = 16'd7; cif.conf_in_data = WC;
    step();
    start = 1'b0;
    cnt_done = 0; cnt_ready = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 2);
      cif.conf_in_data = {$urandom, $urandom};
      @(negedge clk);
      if (done) cnt_done++;
      if (cif.conf_in_ready) cnt_ready++;
      step();
    end
    start = 1'b0;
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    chk("restart_done_count",  TW'(cnt_done),  TW'(1));
    chk("restart_extra_ready", TW'(cnt_ready), TW'(0));

    // Reset in the second DRAIN cycle
    start = 1'b1; num = 16'd1;
    step();
    start = 1'b0;
    cif.conf_in_valid = 1'b1; cif.conf_in_data = WD;
    step();
    cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
    step();
    rst = 1'b0;
    #1;
    chk("abort_taps", taps, '0);
    chk("abort_busy", TW'(busy), TW'(0));
    chk("abort_done", TW'(done), TW'(0));
    step();
    step();
    rst = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
      step();
    end
    chk("abort_no_done", TW'(cnt_done), TW'(0));
    chk("abort_idle",    TW'(cnt_busy), TW'(0));

    // Randomized loads with stalls, stray starts and toggling en
    for (int t = 0; t < 30; t++) begin
      en    = 1'($urandom_range(0, 1));
      start = 1'b1;
      num   = CNTW'($urandom_range(0, 6));
      cif.conf_in_valid = 1'($urandom_range(0, 1));
      cif.conf_in_data  = {$urandom, $urandom};
      step();
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
        cif.conf_in_valid = ($urandom_range(0, 3) != 0);
        cif.conf_in_data  = {$urandom, $urandom};
        en    = 1'($urandom_range(0, 1));
        start = (m_phase != P_IDLE) && ($urandom_range(0, 7) == 0);
        num   = CNTW'($urandom);
        step();
        if (m_phase == P_IDLE) break;
      end
      start = 1'b0;
      cif.conf_in_valid = 1'b0; cif.conf_in_data = '0;
      chk("rand_load_finished", TW'(m_phase == P_IDLE), TW'(1));
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cgra_conf_dist
